// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: the FSM state encoding and
// the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration. The quotient register doubles as the
// dividend shifter: its MSB feeds the partial remainder and the new quotient
// bit enters at its LSB.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of the difference is a true sign.
  always_comb begin
    w_shifted = {i_rem, i_quo[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, i_divisor};
    if (w_diff[WIDTH]) begin
      o_rem = w_shifted[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider: magnitudes are divided with one
// restoring step per cycle, then signs are fixed up in a single cycle.
// A zero divisor skips the iterations and reports div_by_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic             r_negDividend;
  logic             r_negDivisor;
  logic             r_dbz;
  logic             w_accept;
  logic [WIDTH-1:0] w_absDividend;
  logic [WIDTH-1:0] w_absDivisor;
  logic [WIDTH-1:0] w_stepRem;
  logic [WIDTH-1:0] w_stepQuo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_stepRem),
    .o_quo     (w_stepQuo)
  );

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    w_absDividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    w_absDivisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_accept = in_valid;
        if (in_valid) begin
          w_nextState = (divisor == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        if (r_count == '0) begin
          w_nextState = SIGN;
        end
      end
      SIGN: begin
        w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, iteration, sign fix-up; results hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_signed      <= 1'b0;
      r_negDividend <= 1'b0;
      r_negDivisor  <= 1'b0;
      r_dbz         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_signed      <= signed_op;
            r_negDividend <= dividend[WIDTH-1];
            r_negDivisor  <= divisor[WIDTH-1];
            r_divisor     <= w_absDivisor;
            r_count       <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              r_dbz <= 1'b1;
              r_quo <= '1;
              r_rem <= dividend;
            end else begin
              r_dbz <= 1'b0;
              r_quo <= w_absDividend;
              r_rem <= '0;
            end
          end
        end
        DIV: begin
          r_rem <= w_stepRem;
          r_quo <= w_stepQuo;
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end
        end
        SIGN: begin
          if (r_signed && (r_negDividend ^ r_negDivisor)) begin
            r_quo <= -r_quo;
          end
          if (r_signed && r_negDividend) begin
            r_rem <= -r_rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed divides with a scoreboard of
// expected results, back-pressure, divide-by-zero and mid-operation reset.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  exp_t sb[$];
  int   nChecks = 0;
  int   nErrors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result built from the language's own division on magnitudes.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    if (b == '0) begin
      q = '1;
      r = a;
      dbz = 1'b1;
    end else begin
      ma = (s && a[W-1]) ? -a : a;
      mb = (s && b[W-1]) ? -b : b;
      q = ma / mb;
      r = ma % mb;
      if (s && (a[W-1] ^ b[W-1])) q = -q;
      if (s && a[W-1]) r = -r;
      dbz = 1'b0;
    end
  endfunction

  // Wait for in_ready (bounded), perform one accept, scramble inputs after it
  // and record the expected result. Entered and left away from posedge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input logic [W-1:0] expQ, input logic [W-1:0] expR,
                               input logic expDbz, input int lat, input bit record);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("inReadyBeforeAccept", in_ready, 1'b1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'b1;
    if (record) begin
      e.q = expQ;
      e.r = expR;
      e.dbz = expDbz;
      e.lat = lat;
      sb.push_back(e);
    end
  endtask

  // Wait for out_valid counting cycles since the accept, optionally stall
  // out_ready while hammering the input side, then handshake and compare.
  task automatic checkOutput(input int stall);
    exp_t e;
    int   n = 1;
    bit   sawReady = 1'b0;
    check("scoreboardNotEmpty", (sb.size() != 0), 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    @(negedge clk);
    while (!out_valid && n < 200) begin
      if (in_ready) sawReady = 1'b1;
      @(negedge clk);
      n++;
    end
    check("outValidLatency", n, e.lat);
    check("inReadyLowWhileBusy", {sawReady, in_ready, busy, out_valid}, 4'b0011);
    for (int i = 0; i < stall; i++) begin
      in_valid  = 1'b1;
      dividend  = $urandom;
      divisor   = '0;
      signed_op = 1'b0;
      @(negedge clk);
      check("stallHold", {out_valid, in_ready, div_by_zero, quotient, remainder},
            {1'b1, 1'b0, e.dbz, e.q, e.r});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("divByZero", div_by_zero, e.dbz);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idleAfterHandshake", {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin : stimulus
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         s;
    logic         d;
    int           staleValid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    signed_op = 1'b0;
    #12;
    check("resetState", {in_ready, out_valid, busy, div_by_zero, quotient, remainder},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 1'b1);
    checkOutput(0);
    applyStimulus(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    checkOutput(0);
    applyStimulus(32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 1'b1);
    checkOutput(0);
    applyStimulus(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    checkOutput(0);
    applyStimulus(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    checkOutput(0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b1);
    checkOutput(0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1'b1);
    checkOutput(0);
    applyStimulus(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 34, 1'b1);
    checkOutput(10);

    // Abandon an operation at cycle 15 with an asynchronous reset pulse.
    applyStimulus(32'd12345, 32'd67, 1'b0, '0, '0, 1'b0, 0, 1'b0);
    repeat (15) @(negedge clk);
    check("busyBeforeReset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("resetMidOp", {in_ready, out_valid, busy, div_by_zero, quotient, remainder},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    staleValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) staleValid++;
    end
    check("noStaleResult", staleValid, 0);
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 1'b1);
    checkOutput(0);

    // A few random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 1) ? W'($urandom_range(1, 1000)) : W'($urandom);
      s = (i % 3 != 0);
      model(a, b, s, q, r, d);
      applyStimulus(a, b, s, q, r, d, d ? 1 : 34, 1'b1);
      checkOutput(i == 2 ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses only this clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operands and opcode are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port quotient  output  WIDTH  quotient result.
REQ-012 SHALL have port remainder  output  WIDTH  remainder result.
REQ-013 SHALL have port div_by_zero  output  1  set when the accepted divisor was 0; qualified by out_valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL use FSM states IDLE, DIV, SIGN and DONE.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL treat a cycle with in_valid and in_ready both high as an accept (cycle 0); on an accept it SHALL latch signed_op and the operand signs, the operand magnitudes (two's-complement absolute value when signed_op is 1, raw values otherwise) and the zero-divisor condition.
REQ-018 SHALL, on an accept with divisor 0, go IDLE to DONE with quotient all-ones, remainder equal to the original dividend, and div_by_zero set; out_valid SHALL therefore be high in cycle 1.
REQ-019 SHALL, on any other accept, go IDLE to DIV and load the iteration counter with WIDTH-1.
REQ-020 SHALL, in DIV, perform one restoring step per cycle:
- shift the partial remainder left by one, bringing in the next dividend MSB;
- subtract the divisor using a WIDTH+1-bit subtraction;
- if the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore the partial remainder and shift in 0.
REQ-021 SHALL go DIV to SIGN when the counter reaches 0, so the DIV state lasts exactly WIDTH cycles.
REQ-022 SHALL, in SIGN (1 cycle, then DONE):
- negate the quotient if signed_op is 1 and the operand signs differ;
- negate the remainder if signed_op is 1 and the dividend was negative.
REQ-023 SHALL produce quotient 0x80000000 and remainder 0 for the signed case 0x80000000 / 0xFFFFFFFF (WIDTH=32) without any special-case logic.
REQ-024 SHALL hold out_valid high in DONE; out_valid SHALL be high from cycle WIDTH+2 (cycle 34 at WIDTH=32) for a non-zero divisor.
REQ-025 SHALL keep quotient, remainder and div_by_zero stable while out_valid is high and out_ready is low.
REQ-026 SHALL go DONE to IDLE on the cycle out_valid and out_ready are both high; in_ready SHALL rise on the following cycle (no same-cycle accept-and-complete).
REQ-027 SHALL ignore in_valid and input changes in every state except IDLE.
REQ-028 SHALL compute all results modulo 2^WIDTH, with the remainder sign following the dividend.

Reset
REQ-029 SHALL, while rst_n is low, immediately force: state IDLE, in_ready 1, out_valid 0, busy 0, div_by_zero 0, quotient 0, remainder 0, counter 0.
REQ-030 SHALL abandon any in-flight operation when reset asserts mid-operation, and SHALL NOT emit a result for it after reset releases.

Structure
REQ-031 SHALL take the state encoding (2-bit IDLE=0, DIV=1, SIGN=2, DONE=3) and the default WIDTH from the shared package.
REQ-032 SHALL place the single-iteration shift/subtract/select datapath in one combinational sub-module named div_step; the top level holds the FSM, counter and registers.

Verification
REQ-033 SHALL cover: unsigned 100 / 7 -> quotient 14, remainder 2, out_valid at cycle 34, in_ready low throughout.
REQ-034 SHALL cover: signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 SHALL cover: 5 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, out_valid at cycle 1.
REQ-036 SHALL cover: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-037 SHALL cover: out_ready held low for 10 cycles in DONE -> outputs stable and no new accept; then the handshake -> in_ready high one cycle later.
REQ-038 SHALL cover: rst_n pulsed low at cycle 15 of a divide -> all outputs at reset values immediately and no stale out_valid afterwards; a fresh 9 / 3 then completes with quotient 3, remainder 0.
